// File: rtl/clock_divider_multi.sv
// Multi-channel clock/tick generator with runtime-programmable, glitch-free divisors.
// Optional phase-align input enabled by defining CLKDIV_PHASE_ALIGN_EN.
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int CH_BITS     = 2,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [CH_BITS-1:0]  cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic                align,
`endif
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] active_div;
        logic [WIDTH-1:0] shadow_div;
        logic             clk_q;
        logic             tick_q;
        logic             pend_q;
        logic             wr;
        logic             toggle;

        assign wr     = cfg_we && (cfg_ch == CH_BITS'(i));
        assign toggle = en && (cnt == active_div);

        always_ff @(posedge clock) begin
            if (!reset_) begin
                cnt        <= '0;
                active_div <= DIV_RST;
                shadow_div <= DIV_RST;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
                pend_q     <= 1'b0;
            end
`ifdef CLKDIV_PHASE_ALIGN_EN
            else if (align) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                if (pend_q)
                    active_div <= shadow_div;
                // A write in the align cycle is kept for the next toggle
                pend_q <= wr;
                if (wr)
                    shadow_div <= cfg_div;
            end
`endif
            else begin
                tick_q <= 1'b0;
                if (toggle) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= ~clk_q;
                    if (pend_q)
                        active_div <= shadow_div;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
                // Same-cycle write wins: old shadow applied, new one stays pending
                if (wr) begin
                    shadow_div <= cfg_div;
                    pend_q     <= 1'b1;
                end else if (toggle) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (3 channels so cfg_ch=3 is out of range).
// Align scenario runs only when CLKDIV_PHASE_ALIGN_EN is defined.
module tb_clock_divider_multi;

    logic       clock = 1'b0;
    logic       reset_;
    logic       en;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
`ifdef CLKDIV_PHASE_ALIGN_EN
    logic       align;
`endif
    logic [2:0] clk_out;
    logic [2:0] tick;
    logic [2:0] pending;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    clock_divider_multi #(
        .CHANNELS(3),
        .WIDTH(8),
        .CH_BITS(2),
        .DEFAULT_DIV(1)
    ) dut (
        .clock(clock),
        .reset_(reset_),
        .en(en),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
`ifdef CLKDIV_PHASE_ALIGN_EN
        .align(align),
`endif
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] c, input logic [2:0] t,
                          input logic [2:0] p);
        check({tag, " clk_out"}, clk_out, c);
        check({tag, " tick"}, tick, t);
        check({tag, " pending"}, pending, p);
    endtask

    initial begin
        logic [2:0] exp_c [6];
        logic [2:0] exp_t [6];
        reset_  = 1'b0;
        en      = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
        align   = 1'b0;
`endif
        // reset state
        step();
        step();
        check3("reset", 3'b000, 3'b000, 3'b000);

        // default divisor 1: rises edge 2, falls 4, rises 6
        reset_ = 1'b1;
        en     = 1'b1;
        exp_c = '{3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 3'b111};
        exp_t = '{3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111};
        for (int k = 0; k < 6; k++) begin
            step();
            check3($sformatf("default e%0d", k + 1), exp_c[k], exp_t[k], 3'b000);
        end

        // ch1 div=0 written mid half-period (edge 7)
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
        step();
        cfg_we = 1'b0;
        check3("wr ch1 e7", 3'b111, 3'b000, 3'b010);
        exp_c = '{3'b000, 3'b010, 3'b101, 3'b111, 3'b000, 3'b010};
        exp_t = '{3'b000, 3'b010, 3'b101, 3'b010, 3'b000, 3'b010};
        for (int k = 0; k < 6; k++) begin
            step();
            check3($sformatf("div0 e%0d", k + 8), exp_c[k], exp_t[k], 3'b000);
        end

        // freeze 5 cycles, write ch2 div=3 while frozen
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
            end else begin
                cfg_we = 1'b0;
            end
            step();
            check3($sformatf("frozen e%0d", k + 14), 3'b010, 3'b000,
                   (k >= 1) ? 3'b100 : 3'b000);
        end
        en = 1'b1;
        exp_c = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b001, 3'b000};
        exp_t = '{3'b101, 3'b010, 3'b000, 3'b010, 3'b001, 3'b000};
        for (int k = 0; k < 5; k++) begin
            step();
            check3($sformatf("resume e%0d", k + 19), exp_c[k], exp_t[k], 3'b000);
        end

        // write in the applying toggle cycle: old shadow (2) applied, new (0) pending
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        step();
        check("wr0 e24 pending", pending, 3'b001);
        cfg_div = 8'd0;
        step();
        cfg_we = 1'b0;
        check("wr0 e25 pending", pending, 3'b001);
        check("wr0 e25 clk0", {2'b00, clk_out[0]}, 3'b000);
        step();
        check("e26 clk0", {2'b00, clk_out[0]}, 3'b000);
        step();
        check("e27 clk0", {2'b00, clk_out[0]}, 3'b000);
        check("e27 pending", pending, 3'b001);
        step();
        check("e28 clk0", {2'b00, clk_out[0]}, 3'b001);
        check("e28 tick0", {2'b00, tick[0]}, 3'b001);
        check("e28 pending", pending, 3'b000);
        step();
        check("e29 clk0", {2'b00, clk_out[0]}, 3'b000);
        step();
        check("e30 clk0", {2'b00, clk_out[0]}, 3'b001);

        // out-of-range channel ignored
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
        step();
        check("ch3 ignored", pending, 3'b000);
        cfg_ch = 2'd2; cfg_div = 8'd9;
        step();
        cfg_we = 1'b0;
        check("wr ch2 pending", pending, 3'b100);

        // reset mid-period returns everything, including divisors
        reset_ = 1'b0;
        step();
        check3("mid reset", 3'b000, 3'b000, 3'b000);
        reset_ = 1'b1;
        step();
        check3("post reset e1", 3'b000, 3'b000, 3'b000);
        step();
        check3("post reset e2", 3'b111, 3'b111, 3'b000);

`ifdef CLKDIV_PHASE_ALIGN_EN
        en = 1'b0;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        step();
        cfg_ch = 2'd1; cfg_div = 8'd5;
        step();
        cfg_we = 1'b0;
        check("pre align pending", pending, 3'b011);
        align = 1'b1;
        step();
        align = 1'b0;
        en    = 1'b1;
        check3("align", 3'b000, 3'b000, 3'b000);
        exp_c = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b010};
        exp_t = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010};
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("aligned clk k%0d", k + 1), {1'b0, clk_out[1:0]}, exp_c[k]);
            check($sformatf("aligned tick k%0d", k + 1), {1'b0, tick[1:0]}, exp_t[k]);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
